// File: rtl/rejestr_wyniku_pkg.sv
// Shared types and constants for the rejestr_wyniku result/status output stage.
package rejestr_wyniku_pkg;

    localparam int unsigned DEF_BITS     = 32;
    localparam int unsigned DEF_CNT_BITS = 16;

    localparam int unsigned ST_ERR  = 3;
    localparam int unsigned ST_OVF  = 2;
    localparam int unsigned ST_ZERO = 1;
    localparam int unsigned ST_NEG  = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stan_e;

endpackage

// File: rtl/rejestr_wyniku_status_kodowanie.sv
// Combinational encoder: raw unit result and flags -> stored result and 4-bit status word.
module status_kodowanie
    import rejestr_wyniku_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS
) (
    input  logic [BITS-1:0] result_i,
    input  logic            error_i,
    input  logic            overflow_i,
    output logic [BITS-1:0] result_o,
    output logic [3:0]      status_o
);

    logic [BITS-1:0] wynik;

    // An error masks both the result value and the overflow flag.
    always_comb begin
        wynik    = result_i;
        status_o = '0;
        if (error_i) begin
            wynik            = '0;
            status_o[ST_ERR] = 1'b1;
        end else begin
            status_o[ST_OVF] = overflow_i;
        end
        status_o[ST_ZERO] = (wynik == '0);
        status_o[ST_NEG]  = wynik[BITS-1];
        result_o          = wynik;
    end

endmodule

// File: rtl/rejestr_wyniku.sv
// Registered 2-entry result/status output stage with valid/ready on both sides.
// Optional event counters are enabled by defining STATUS_COUNTERS_EN.
module rejestr_wyniku
    import rejestr_wyniku_pkg::*;
#(
    parameter int unsigned BITS     = DEF_BITS,
    parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [BITS-1:0]     i_result,
    input  logic                i_error,
    input  logic                i_overflow,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [BITS-1:0]     o_result,
    output logic [3:0]          o_status,
    input  logic                i_cnt_clr,
    output logic [CNT_BITS-1:0] o_err_cnt,
    output logic [CNT_BITS-1:0] o_ovf_cnt
);

    stan_e           stan_q, stan_d;
    logic [BITS-1:0] wynik_q [2];
    logic [3:0]      status_q [2];
    logic            glowa_q, ogon_q;
    logic [BITS-1:0] enc_result;
    logic [3:0]      enc_status;
    logic            push, pop;

    status_kodowanie #(
        .BITS(BITS)
    ) u_kodowanie (
        .result_i   (i_result),
        .error_i    (i_error),
        .overflow_i (i_overflow),
        .result_o   (enc_result),
        .status_o   (enc_status)
    );

    // o_ready depends only on state and reset, never on i_ready.
    assign o_ready  = !i_rst && (stan_q != FULL);
    assign o_valid  = (stan_q != EMPTY);
    assign push     = i_valid && o_ready;
    assign pop      = o_valid && i_ready;
    assign o_result = wynik_q[glowa_q];
    assign o_status = status_q[glowa_q];

    always_comb begin
        stan_d = stan_q;
        case (stan_q)
            EMPTY: if (push) stan_d = ONE;
            ONE: begin
                if (push && !pop)      stan_d = FULL;
                else if (pop && !push) stan_d = EMPTY;
            end
            FULL:    if (pop) stan_d = ONE;
            default: stan_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stan_q  <= EMPTY;
            glowa_q <= 1'b0;
            ogon_q  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                wynik_q[i]  <= '0;
                status_q[i] <= '0;
            end
        end else begin
            stan_q <= stan_d;
            if (push) begin
                wynik_q[ogon_q]  <= enc_result;
                status_q[ogon_q] <= enc_status;
                ogon_q           <= ~ogon_q;
            end
            if (pop) begin
                glowa_q <= ~glowa_q;
            end
        end
    end

`ifdef STATUS_COUNTERS_EN
    logic [CNT_BITS-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_BITS-1:0] ovf_cnt_q, ovf_cnt_d;

    // Clear takes precedence over a same-cycle increment; counts stick at all ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (i_cnt_clr) begin
            err_cnt_d = '0;
            ovf_cnt_d = '0;
        end else if (pop) begin
            if (o_status[ST_ERR] && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_BITS'(1);
            if (o_status[ST_OVF] && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
    assign o_ovf_cnt = ovf_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = i_cnt_clr;
    assign o_err_cnt      = '0;
    assign o_ovf_cnt      = '0;
`endif

endmodule

// File: tb/tb_rejestr_wyniku.sv
// Scoreboard bench for rejestr_wyniku: queue-based occupancy/content model plus directed scenarios.
module tb_rejestr_wyniku;

    localparam int unsigned BITS     = 32;
    localparam int unsigned CNT_BITS = 16;
    localparam int unsigned CNT_MAX  = (1 << CNT_BITS) - 1;
`ifdef STATUS_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                i_clk, i_rst, i_valid, o_ready, i_error, i_overflow;
    logic                o_valid, i_ready, i_cnt_clr;
    logic [BITS-1:0]     i_result, o_result;
    logic [3:0]          o_status;
    logic [CNT_BITS-1:0] o_err_cnt, o_ovf_cnt;

    rejestr_wyniku #(
        .BITS     (BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_result   (i_result),
        .i_error    (i_error),
        .i_overflow (i_overflow),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_status   (o_status),
        .i_cnt_clr  (i_cnt_clr),
        .o_err_cnt  (o_err_cnt),
        .o_ovf_cnt  (o_ovf_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [BITS-1:0] r;
        logic [3:0]      s;
    } wpis_t;

    wpis_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned err_m  = 0;
    int unsigned ovf_m  = 0;
    int unsigned pops_dut = 0;

    // Expected stored entry from the arithmetic-unit output rules.
    function automatic wpis_t oczekiwany(logic [BITS-1:0] r, logic e, logic o);
        wpis_t w;
        if (e) begin
            w.r = '0;
            w.s = 4'b1010;
        end else begin
            w.r = r;
            w.s = {1'b0, o, (r == 0), (r >= 32'h8000_0000)};
        end
        return w;
    endfunction

    task automatic sprawdz(input string nazwa, input logic [63:0] akt, input logic [63:0] ocz);
        checks++;
        if (akt !== ocz) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nazwa, akt, ocz, $time);
        end
    endtask

    // Monitor: compares DUT against the queue model, then advances the model for the coming edge.
    always @(negedge i_clk) begin
        bit m_pop, m_push;
        sprawdz("o_ready", o_ready, (!i_rst && sb.size() < 2));
        sprawdz("o_valid", o_valid, (sb.size() != 0));
        if (sb.size() != 0) begin
            sprawdz("o_result", o_result, sb[0].r);
            sprawdz("o_status", o_status, sb[0].s);
        end
        sprawdz("o_err_cnt", o_err_cnt, CNT_EN ? err_m : 0);
        sprawdz("o_ovf_cnt", o_ovf_cnt, CNT_EN ? ovf_m : 0);
        if (o_valid && i_ready) pops_dut++;
        if (i_rst) begin
            sb.delete();
            err_m = 0;
            ovf_m = 0;
        end else begin
            m_pop  = i_ready && (sb.size() != 0);
            m_push = i_valid && (sb.size() < 2);
            if (i_cnt_clr) begin
                err_m = 0;
                ovf_m = 0;
            end else if (m_pop) begin
                if (sb[0].s[3] && err_m < CNT_MAX) err_m++;
                if (sb[0].s[2] && ovf_m < CNT_MAX) ovf_m++;
            end
            if (m_pop) void'(sb.pop_front());
            if (m_push) sb.push_back(oczekiwany(i_result, i_error, i_overflow));
        end
    end

    task automatic krok();
        @(posedge i_clk);
        #1;
    endtask

    // Offer one entry and hold it until the edge that accepts it.
    task automatic podaj(input logic [BITS-1:0] r, input logic e, input logic o);
        int unsigned n;
        i_valid    = 1'b1;
        i_result   = r;
        i_error    = e;
        i_overflow = o;
        n = 0;
        while (!o_ready && n < 20) begin
            krok();
            n++;
        end
        if (!o_ready) begin
            errors++;
            $display("FAIL push_timeout actual=o_ready_low expected=o_ready_high t=%0t", $time);
        end
        krok();
        i_valid = 1'b0;
    endtask

    initial begin
        int unsigned p0;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_result = '0;
        i_error = 1'b0; i_overflow = 1'b0; i_cnt_clr = 1'b0;

        // Reset
        krok(); krok();
        sprawdz("rst_o_valid", o_valid, 0);
        sprawdz("rst_o_result", o_result, 0);
        sprawdz("rst_o_status", o_status, 0);
        sprawdz("rst_o_ready", o_ready, 0);
        i_rst = 1'b0;
        krok();
        sprawdz("rel_o_ready", o_ready, 1);

        // Single transfer
        i_ready = 1'b1;
        podaj(32'h0000_0010, 1'b0, 1'b0);
        sprawdz("single_valid", o_valid, 1);
        sprawdz("single_result", o_result, 32'h10);
        sprawdz("single_status", o_status, 4'b0000);
        krok();
        sprawdz("single_drain", o_valid, 0);

        // Backpressure: third entry waits until space frees up
        i_ready = 1'b0;
        podaj(32'd1, 1'b0, 1'b0);
        podaj(32'd2, 1'b0, 1'b0);
        i_valid = 1'b1; i_result = 32'd3;
        krok(); krok();
        sprawdz("bp_full_ready", o_ready, 0);
        sprawdz("bp_head", o_result, 32'd1);
        i_ready = 1'b1;
        podaj(32'd3, 1'b0, 1'b0);
        krok(); krok(); krok();
        sprawdz("bp_drained", o_valid, 0);

        // Flag encoding
        i_ready = 1'b0;
        podaj(32'hDEAD_BEEF, 1'b1, 1'b0);
        sprawdz("err_result", o_result, 0);
        sprawdz("err_status", o_status, 4'b1010);
        i_ready = 1'b1; krok(); i_ready = 1'b0;
        podaj(32'h8000_0000, 1'b0, 1'b1);
        sprawdz("ovf_status", o_status, 4'b0101);
        i_ready = 1'b1; krok();

        // Throughput in ONE: one result per cycle
        i_ready = 1'b0;
        podaj(32'h55, 1'b0, 1'b0);
        i_ready = 1'b1; i_valid = 1'b1;
        p0 = pops_dut;
        for (int i = 0; i < 20; i++) begin
            i_result = $urandom;
            krok();
        end
        sprawdz("throughput", pops_dut - p0, 20);
        i_valid = 1'b0;
        krok(); krok();

        // Reset while FULL flushes both entries
        i_ready = 1'b0;
        podaj(32'hA, 1'b0, 1'b0);
        podaj(32'hB, 1'b0, 1'b0);
        sprawdz("full_ready", o_ready, 0);
        i_rst = 1'b1;
        krok();
        sprawdz("flush_valid", o_valid, 0);
        sprawdz("flush_result", o_result, 0);
        i_rst = 1'b0;
        krok();
        sprawdz("flush_ready", o_ready, 1);

        // Event counters
        i_ready = 1'b1;
        i_cnt_clr = 1'b1; krok(); i_cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) podaj($urandom, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) podaj($urandom, 1'b0, 1'b1);
        krok(); krok();
        sprawdz("err_cnt_3", o_err_cnt, CNT_EN ? 3 : 0);
        sprawdz("ovf_cnt_2", o_ovf_cnt, CNT_EN ? 2 : 0);
        i_cnt_clr = 1'b1; krok(); i_cnt_clr = 1'b0;
        sprawdz("err_cnt_clr", o_err_cnt, 0);
        sprawdz("ovf_cnt_clr", o_ovf_cnt, 0);

        // Randomised traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            i_valid    = ($urandom_range(0, 1) == 1);
            i_ready    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       i_result = '0;
                1:       i_result = 32'h8000_0000 | $urandom;
                default: i_result = $urandom;
            endcase
            i_error    = ($urandom_range(0, 7) == 0);
            i_overflow = ($urandom_range(0, 3) == 0);
            i_cnt_clr  = ($urandom_range(0, 31) == 0);
            i_rst      = ($urandom_range(0, 63) == 0);
            krok();
        end
        i_valid = 1'b0; i_ready = 1'b1; i_rst = 1'b0; i_cnt_clr = 1'b0;
        krok(); krok(); krok();
        sprawdz("final_empty", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
